// File: rtl/packer_ctrl.sv
// packer_ctrl
//   Control sequencer for the trace-path vector packer. Accepts blocks of
//   1, M or N values, tracks the fill level of the vector being built and
//   drives per-beat write controls (offset / in-vector count / spill count)
//   to the packer datapath. Owns the output valid/ready handshake and the
//   end-of-trace flush that zero-pads and emits a partial vector.
//
//   Optional build macro: PACKER_CTRL_STATS_EN adds saturating statistics
//   counters (stat_vectors, stat_partial, stat_dropped).
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   tracing          trace enable from the trace controller
//   valid_in         input block valid
//   size_sel         block size: 0=1, 1=M, 2=N, 3=reserved (dropped)
//   in_ready         block accepted when valid_in && in_ready
//   wr_en            datapath write strobe, same cycle as accept
//   wr_offset        start lane in the current vector
//   wr_lo            values written into the current vector
//   wr_hi            values spilled into lanes 0.. of the next vector
//   wr_pad           datapath zero-fills lanes fill..N-1 this cycle
//   out_valid        packed vector available
//   out_partial      qualifies out_valid: vector was flush-padded
//   out_ready        downstream accepts the vector
//   drop_err         one-cycle pulse after a reserved-size accept
//
// State table
//   IDLE  | not tracing, inputs ignored
//   PACK  | accepting blocks and building vectors
//   FLUSH | trace ended, pad and emit any partial vector, then IDLE

module packer_ctrl #(
  parameter  int N  = 8,
  parameter  int M  = 4,
  localparam int FW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tracing,
  input  logic          valid_in,
  input  logic [1:0]    size_sel,
  output logic          in_ready,
  output logic          wr_en,
  output logic [FW-2:0] wr_offset,
  output logic [FW-1:0] wr_lo,
  output logic [FW-1:0] wr_hi,
  output logic          wr_pad,
  output logic          out_valid,
  output logic          out_partial,
  input  logic          out_ready,
  output logic          drop_err
`ifdef PACKER_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_vectors,
  output logic [31:0]   stat_partial,
  output logic [31:0]   stat_dropped
`endif
);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t        state;
  logic [FW-1:0] fill;
  logic [FW-1:0] cnt;
  logic          cnt_ok;
  logic          accept;
  logic [FW-1:0] sum;
  logic          wraps;
  logic          out_free;

  always_comb begin
    cnt    = '0;
    cnt_ok = 1'b1;
    case (size_sel)
      2'd0:    cnt = FW'(1);
      2'd1:    cnt = FW'(M);
      2'd2:    cnt = FW'(N);
      default: cnt_ok = 1'b0;
    endcase
  end

  // Output slot is free when empty or being drained this cycle.
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == PACK) && out_free;
  assign accept    = valid_in && in_ready;
  // fill <= N-1 and cnt <= N, so the sum fits in FW bits.
  assign sum       = fill + cnt;
  assign wraps     = sum >= FW'(N);
  assign wr_en     = accept && cnt_ok;
  assign wr_offset = fill[FW-2:0];
  assign wr_lo     = wraps ? (FW'(N) - fill) : cnt;
  assign wr_hi     = wraps ? (sum - FW'(N)) : '0;
  assign wr_pad    = (state == FLUSH) && (fill != '0) && out_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fill        <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      drop_err <= accept && !cnt_ok;

      // Drain first; a vector completing on the same edge overrides below.
      if (out_valid && out_ready) begin
        out_valid   <= 1'b0;
        out_partial <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tracing) state <= PACK;
        end
        PACK: begin
          if (wr_en) begin
            if (wraps) begin
              fill        <= sum - FW'(N);
              out_valid   <= 1'b1;
              out_partial <= 1'b0;
            end else begin
              fill <= sum;
            end
          end
          if (!tracing) state <= FLUSH;
        end
        FLUSH: begin
          if (fill == '0) begin
            state <= IDLE;
          end else if (wr_pad) begin
            out_valid   <= 1'b1;
            out_partial <= 1'b1;
            fill        <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PACKER_CTRL_STATS_EN
  logic drop_evt;
  assign drop_evt = (accept && !cnt_ok) ||
                    (valid_in && ((state == IDLE) || (state == FLUSH)));

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_vectors <= '0;
      stat_partial <= '0;
      stat_dropped <= '0;
    end else begin
      if (out_valid && out_ready && (stat_vectors != '1))
        stat_vectors <= stat_vectors + 32'd1;
      if (wr_pad && (stat_partial != '1))
        stat_partial <= stat_partial + 32'd1;
      if (drop_evt && (stat_dropped != '1))
        stat_dropped <= stat_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packer_ctrl.sv
// tb_packer_ctrl
//   Self-checking bench for packer_ctrl (N=8, M=4): a directed vector table,
//   hand-written multi-cycle sequences and a randomized run against a
//   behavioural reference model.

module tb_packer_ctrl;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int FW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset, tracing, valid_in, out_ready;
  logic [1:0]    size_sel;
  logic          in_ready, wr_en, wr_pad, out_valid, out_partial, drop_err;
  logic [FW-2:0] wr_offset;
  logic [FW-1:0] wr_lo, wr_hi;
`ifdef PACKER_CTRL_STATS_EN
  logic [31:0]   stat_vectors, stat_partial, stat_dropped;
`endif

  packer_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
    .size_sel(size_sel), .in_ready(in_ready), .wr_en(wr_en),
    .wr_offset(wr_offset), .wr_lo(wr_lo), .wr_hi(wr_hi), .wr_pad(wr_pad),
    .out_valid(out_valid), .out_partial(out_partial), .out_ready(out_ready),
    .drop_err(drop_err)
`ifdef PACKER_CTRL_STATS_EN
    , .stat_vectors(stat_vectors), .stat_partial(stat_partial),
    .stat_dropped(stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change 1 time unit after the edge, outputs are compared 2 units later.
  task automatic apply(input logic r, input logic t, input logic v,
                       input logic [1:0] s, input logic o);
    reset = r; tracing = t; valid_in = v; size_sel = s; out_ready = o;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0);
    step();
  endtask

  typedef struct {
    logic       r, t, v;
    logic [1:0] s;
    logic       o;
    int ir, we, off, lo, hi, pad, ov, op, de;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic t, input logic v,
                              input logic [1:0] s, input logic o,
                              input int ir, input int we, input int off,
                              input int lo, input int hi, input int pad,
                              input int ov, input int op, input int de);
    vec_t x;
    x.r = r; x.t = t; x.v = v; x.s = s; x.o = o;
    x.ir = ir; x.we = we; x.off = off; x.lo = lo; x.hi = hi;
    x.pad = pad; x.ov = ov; x.op = op; x.de = de;
    return x;
  endfunction

  vec_t tbl[18];

  // Reference model state
  int mfill;
  bit mact, mflush, mov, mop, mde;

  task automatic model_cycle(input logic r, input logic t, input logic v,
                             input logic [1:0] s, input logic o);
    int cnt, e_ir, e_we, e_pad, e_lo, e_hi;
    bit acc, comp, hs;
    cnt   = (s == 0) ? 1 : (s == 1) ? M : (s == 2) ? N : 0;
    e_ir  = (mact && (!mov || o)) ? 1 : 0;
    acc   = v && (e_ir != 0);
    e_we  = (acc && s != 3) ? 1 : 0;
    e_pad = (mflush && mfill > 0 && (!mov || o)) ? 1 : 0;
    if (mfill + cnt < N) begin e_lo = cnt; e_hi = 0; end
    else begin e_lo = N - mfill; e_hi = mfill + cnt - N; end

    chk("rnd_in_ready", int'(in_ready), e_ir);
    chk("rnd_wr_en", int'(wr_en), e_we);
    chk("rnd_wr_pad", int'(wr_pad), e_pad);
    chk("rnd_out_valid", int'(out_valid), int'(mov));
    chk("rnd_out_partial", int'(out_partial), int'(mop));
    chk("rnd_drop_err", int'(drop_err), int'(mde));
    if (e_we != 0) begin
      chk("rnd_wr_offset", int'(wr_offset), mfill);
      chk("rnd_wr_lo", int'(wr_lo), e_lo);
      chk("rnd_wr_hi", int'(wr_hi), e_hi);
    end

    if (r) begin
      mfill = 0; mact = 0; mflush = 0; mov = 0; mop = 0; mde = 0;
    end else begin
      hs   = mov && o;
      comp = (e_we != 0) && (mfill + cnt >= N);
      mde  = acc && (s == 3);
      if (comp || e_pad != 0) begin
        mov = 1; mop = (e_pad != 0);
      end else if (hs) begin
        mov = 0; mop = 0;
      end
      if (mflush) begin
        if (mfill == 0 || e_pad != 0) mflush = 0;
      end else if (mact) begin
        if (!t) begin mact = 0; mflush = 1; end
      end else if (t) begin
        mact = 1;
      end
      if (e_we != 0) mfill = (mfill + cnt) % N;
      if (e_pad != 0) mfill = 0;
    end
  endtask

  initial begin
    reset = 1; tracing = 0; valid_in = 0; size_sel = 0; out_ready = 0;

    //            r  t  v  s  o   ir we off lo hi pad ov op de
    tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 1,  1, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 1,  1, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 1,  1, 1, 2, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 1, 1,  1, 1, 3, 4, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 1, 1,  1, 1, 7, 1, 3, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 3, 1,  1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 1, 2, 1,  1, 1, 3, 5, 3, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 1,  1, 1, 3, 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[16] = mk(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[17] = mk(0, 1, 1, 0, 1,  1, 1, 0, 1, 0, 0, 0, 0, 0);

    #1;
    do_reset();

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].r, tbl[i].t, tbl[i].v, tbl[i].s, tbl[i].o);
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), tbl[i].ir);
      chk($sformatf("tbl%0d_wr_en", i), int'(wr_en), tbl[i].we);
      chk($sformatf("tbl%0d_wr_pad", i), int'(wr_pad), tbl[i].pad);
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), tbl[i].ov);
      chk($sformatf("tbl%0d_out_partial", i), int'(out_partial), tbl[i].op);
      chk($sformatf("tbl%0d_drop_err", i), int'(drop_err), tbl[i].de);
      if (tbl[i].we != 0) begin
        chk($sformatf("tbl%0d_wr_offset", i), int'(wr_offset), tbl[i].off);
        chk($sformatf("tbl%0d_wr_lo", i), int'(wr_lo), tbl[i].lo);
        chk($sformatf("tbl%0d_wr_hi", i), int'(wr_hi), tbl[i].hi);
      end
      step();
    end

    // Eight single-value blocks fill exactly one vector
    do_reset();
    apply(0, 1, 0, 0, 1); step();
    for (int i = 0; i < N; i++) begin
      apply(0, 1, 1, 0, 1);
      chk("single_wr_en", int'(wr_en), 1);
      chk("single_wr_offset", int'(wr_offset), i);
      chk("single_wr_lo", int'(wr_lo), 1);
      chk("single_wr_hi", int'(wr_hi), 0);
      chk("single_no_early_valid", int'(out_valid), 0);
      step();
    end
    apply(0, 1, 0, 0, 1);
    chk("single_out_valid", int'(out_valid), 1);
    chk("single_out_partial", int'(out_partial), 0);
    step();
    apply(0, 1, 1, 0, 1);
    chk("single_valid_pulse", int'(out_valid), 0);
    chk("single_fill_zero", int'(wr_offset), 0);
    step();

    // Backpressure: held out_valid blocks input for 5 cycles
    do_reset();
    apply(0, 1, 0, 0, 1); step();
    apply(0, 1, 1, 2, 1);
    chk("bp_full_lo", int'(wr_lo), N);
    chk("bp_full_hi", int'(wr_hi), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 1, 0, 0);
      chk("bp_out_valid_held", int'(out_valid), 1);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_no_wr_en", int'(wr_en), 0);
      step();
    end
    apply(0, 1, 1, 0, 1);
    chk("bp_in_ready_back", int'(in_ready), 1);
    chk("bp_accept_offset", int'(wr_offset), 0);
    step();
    apply(0, 1, 0, 0, 1);
    chk("bp_handshake_clears", int'(out_valid), 0);
    step();

    // Reset with fill=5 and a pending vector
    do_reset();
    apply(0, 1, 0, 0, 1); step();
    apply(0, 1, 1, 0, 1); step();
    apply(0, 1, 1, 1, 1); step();
    apply(0, 1, 1, 2, 1);
    chk("rst_pre_offset", int'(wr_offset), 5);
    chk("rst_pre_lo", int'(wr_lo), 3);
    chk("rst_pre_hi", int'(wr_hi), 5);
    step();
    apply(1, 1, 0, 0, 0);
    chk("rst_pre_out_valid", int'(out_valid), 1);
    step();
    apply(0, 1, 1, 0, 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_idle_in_ready", int'(in_ready), 0);
    step();
    apply(0, 1, 1, 0, 1);
    chk("rst_fill_zero", int'(wr_offset), 0);
    step();

    // Randomized run against the reference model
    do_reset();
    mfill = 0; mact = 0; mflush = 0; mov = 0; mop = 0; mde = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, t, v, o;
      logic [1:0] s;
      r = ($urandom_range(0, 149) == 0);
      t = ($urandom_range(0, 11) != 0);
      v = $urandom_range(0, 1) == 1;
      s = 2'($urandom_range(0, 3));
      o = ($urandom_range(0, 3) != 0);
      apply(r, t, v, s, o);
      model_cycle(r, t, v, s, o);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/packer_ctrl.md
Name: packer_ctrl

Overview:
- Control sequencer for the vector data packer in the trace path.
- Accepts blocks of 1, M or N values.
- Tracks the packer fill level and generates per-beat write offset/count/spill controls for the packer datapath.
- Owns output valid/ready backpressure, and the end-of-trace flush that pads and emits a partial vector.

Parameters:
- N, 8, output vector length in values; power of two, >=2
- M, 4, medium block size; power of two, 1 < M < N
- FW, $clog2(N)+1, fill/count width (derived, not overridden)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tracing  in  1  trace enable from the trace controller
- valid_in  in  1  input block valid
- size_sel  in  2  block size: 0=1 value, 1=M, 2=N, 3=reserved
- in_ready  out  1  block accepted when valid_in&&in_ready
- wr_en  out  1  datapath write strobe (comb, same cycle as accept)
- wr_offset  out  FW-1  start lane in the current vector
- wr_lo  out  FW  values written into the current vector
- wr_hi  out  FW  values spilled into lanes 0.. of the next vector
- wr_pad  out  1  datapath zero-fills lanes fill..N-1 this cycle
- out_valid  out  1  packed vector available
- out_partial  out  1  qualifies out_valid: vector was flush-padded
- out_ready  in  1  downstream accepts the vector
- drop_err  out  1  one-cycle pulse: reserved size_sel accepted and discarded

Behaviour:
- States: IDLE, PACK, FLUSH.
- Reset (sync, any state): state=IDLE, fill=0, out_valid=0, out_partial=0, drop_err=0. Any partial vector is discarded.
- IDLE:
  - in_ready=0; valid_in is ignored.
  - tracing=1 -> PACK on the next edge.
- PACK:
  - in_ready = !out_valid || out_ready.
  - On accept with cnt in {1,M,N}: new = fill+cnt; wr_en=1, wr_offset=fill.
  - new<N: wr_lo=cnt, wr_hi=0, fill<=new.
  - new>=N: wr_lo=N-fill, wr_hi=new-N, fill<=new-N; out_valid<=1 and out_partial<=0 at the same edge.
  - size_sel=3: accepted, wr_en=0, fill unchanged, drop_err pulses the next cycle.
- Output handshake:
  - out_valid held until out_ready; out_valid&&out_ready clears it unless a new vector completes on the same edge, in which case it stays 1.
  - The datapath must present vector_out stable while out_valid&&!out_ready.
- tracing 1->0 while in PACK -> FLUSH next edge. A block presented in that same cycle is still accepted.
- FLUSH:
  - in_ready=0.
  - fill==0 -> IDLE.
  - fill>0: wait until !out_valid||out_ready, then wr_pad=1 for one cycle; out_valid<=1, out_partial<=1, fill<=0 -> IDLE.
  - tracing re-asserted during FLUSH does not abort; the flush completes, then IDLE->PACK.
- Wrap: fill is always in 0..N-1 after every edge. wr_hi < N is guaranteed because cnt<=N.
- All arithmetic unsigned, FW bits; no overflow is possible given the parameter constraints.

Optional Feature:
- Macro PACKER_CTRL_STATS_EN.
- When defined:
  - Adds outputs stat_vectors (32b, count of out_valid&&out_ready handshakes), stat_partial (32b, flush-emitted vectors) and stat_dropped (32b, reserved-size accepts plus valid_in seen in IDLE or FLUSH).
  - Counters saturate at all-ones and clear on reset.
- When undefined: the ports and logic are absent; other behaviour is identical.

Test Plan:
- N=8,M=4, 8 single-value blocks with out_ready=1 -> wr_offset 0..7, wr_lo=1, single out_valid pulse after the 8th accept, out_partial=0, fill=0.
- Blocks 1,1,1 then M=4 then M=4 -> on the 5th block fill=7: wr_offset=7, wr_lo=1, wr_hi=3; out_valid next cycle; fill=3.
- Complete a vector with out_ready=0 for 5 cycles -> out_valid held, in_ready=0 for 5 cycles, no wr_en; then out_ready=1 -> handshake, in_ready=1.
- 3 single values, then tracing=0 -> FLUSH, wr_pad=1 once, out_valid=1 with out_partial=1, state IDLE, fill=0.
- Assert reset with fill=5 and out_valid=1 -> next cycle out_valid=0, fill=0, IDLE; size_sel=3 accept in PACK -> drop_err pulse, fill unchanged.
